temp_sensor_sequencer: RTL and testbench
========================================

Name: temp_sensor_sequencer

Overview:
- Front end that produces the four parallel temperature words used by the averaging/over-temperature comparator.
- Polls four sensors one at a time over a shared req/ack read interface, with a per-channel timeout.
- Collects the results in shadow registers, then publishes all four words together with a one-cycle frame strobe.
- Downstream logic therefore always sees a coherent set of four readings from a single sweep.

Parameters:
- W, 8: temperature word width (matches the comparator datapath).
- TO_CYCLES, 16: maximum number of REQ cycles to wait for sens_ack before abandoning a channel; must be ≥1.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > TO_CYCLES.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a four-channel sweep; sampled only in IDLE.
- sens_req, out, 1: read request to the sensor selected by sens_sel.
- sens_sel, out, 2: channel index 0..3.
- sens_ack, in, 1: sensor data valid; meaningful only while sens_req=1.
- sens_data, in, W: reading; captured on the edge where sens_req=1 and sens_ack=1.
- temp1, out, W: published channel 0 reading.
- temp2, out, W: published channel 1 reading.
- temp3, out, W: published channel 2 reading.
- temp4, out, W: published channel 3 reading.
- frame_valid, out, 1: one-cycle pulse; temp1..4 and err_mask were updated on this edge.
- err_mask, out, 4: bit i=1 means channel i timed out in the last published frame.
- busy, out, 1: high whenever state≠IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; sens_req=0; sens_sel=0; temp1..4=0; shadow regs=0; err_mask=0; frame_valid=0; timeout counter=0; pending error bits=0. Reset asserted mid-sweep aborts the sweep, drops sens_req immediately and publishes nothing.
- States: IDLE, REQ, GAP, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: sens_req=0. If start=1, go to REQ with sens_sel=0, counter=0 and pending errors cleared.
- REQ: sens_req=1.
  - On an edge with sens_ack=1: shadow[sens_sel]←sens_data, go to GAP.
  - Else, if counter==TO_CYCLES-1: set pending_err[sens_sel], leave shadow[sens_sel] unchanged (keeps the previous frame's value), go to GAP.
  - Else: counter+1.
  - An ack on the final allowed cycle wins over the timeout.
- GAP: sens_req=0 for exactly one cycle, so requests are never back-to-back.
  - If sens_sel==3, go to DONE.
  - Else sens_sel+1, counter=0, go to REQ.
- DONE: on entry edge, temp1..4←shadow[0..3] and err_mask←pending_err. frame_valid=1 for this single cycle. Next state is IDLE.
- start outside IDLE is ignored; no queuing. sens_ack outside REQ is ignored. start held high continuously gives back-to-back sweeps with one IDLE cycle between frames.
- Latency with sens_ack tied high:
  - start sampled at edge 0; REQ ch0 in cycle 1.
  - REQ/GAP pairs occupy cycles 1–8.
  - DONE (frame_valid=1) in cycle 9; IDLE and busy=0 in cycle 10.
  - Total: 9 cycles start-to-frame.
- Worst case, all channels timing out: 4·(TO_CYCLES+1)+1 cycles start-to-frame.
- temp1..4 are stable between frame_valid pulses.
- Widths: data passes through unmodified at W bits; no arithmetic on data.

Test Plan:
- Zero-wait: ack tied 1; sensors return 8'h10, 8'h20, 8'h30, 8'h40; start pulse at cycle 0 → sens_sel sequence 0,1,2,3 on REQ cycles 1,3,5,7; frame_valid only in cycle 9; temp1..4=10/20/30/40; err_mask=0000.
- Wait states: ch2 acks after 5 REQ cycles with 8'h7F, others immediate → frame_valid 4 cycles later than zero-wait (cycle 13); temp3=7F; err_mask=0000; sens_req never high on two consecutive channels without a GAP cycle.
- Timeout: frame 1 all OK (temp2=8'h22), frame 2 ch1 never acks → sens_req drops after exactly 16 REQ cycles; frame 2 publishes temp2=8'h22 and err_mask=0010; frame 3 all OK clears err_mask to 0000.
- Boundary ack: ch0 acks on the 16th REQ cycle with 8'h55 → temp1=55, err_mask[0]=0.
- Ignored inputs: start pulses during REQ/GAP/DONE and spurious sens_ack during IDLE/GAP → no extra sweep, no data capture, exactly one frame_valid per accepted start.
- Reset mid-sweep: assert rst during REQ ch2 → sens_req=0 immediately (same cycle); all outputs 0; no frame_valid; next start performs a full clean sweep.

Source files
------------

// File: rtl/temp_sensor_sequencer.sv
// temp_sensor_sequencer: polls four sensors over a shared req/ack bus and publishes a coherent frame
module temp_sensor_sequencer #(
  parameter int W = 8,
  parameter int TO_CYCLES = 16,
  parameter int TO_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         sens_req,
  output logic [1:0]   sens_sel,
  input  logic         sens_ack,
  input  logic [W-1:0] sens_data,
  output logic [W-1:0] temp1,
  output logic [W-1:0] temp2,
  output logic [W-1:0] temp3,
  output logic [W-1:0] temp4,
  output logic         frame_valid,
  output logic [3:0]   err_mask,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;
  state_t state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic [W-1:0] shadow [4];
  logic [3:0] pend;
  logic tmo, last;
  assign tmo = cnt == TO_W'(TO_CYCLES - 1);
  assign last = sens_sel == 2'd3;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (start ? REQ : IDLE) :
                (state == REQ)  ? ((sens_ack || tmo) ? GAP : REQ) :
                (state == GAP)  ? (last ? DONE : REQ) : IDLE;
  always_comb begin
    sens_req = state == REQ;
    busy = state != IDLE;
    frame_valid = state == DONE;
  end
  // shadows collect a sweep; published words only change on the edge entering DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sens_sel <= '0;
      cnt <= '0;
      pend <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      temp1 <= '0;
      temp2 <= '0;
      temp3 <= '0;
      temp4 <= '0;
      err_mask <= '0;
    end else begin
      if (state == IDLE && start) begin
        sens_sel <= '0;
        cnt <= '0;
        pend <= '0;
      end
      if (state == REQ) begin
        if (sens_ack) shadow[sens_sel] <= sens_data;
        else if (tmo) pend[sens_sel] <= 1'b1;
        else cnt <= cnt + TO_W'(1);
      end
      if (state == GAP && !last) begin
        sens_sel <= sens_sel + 2'd1;
        cnt <= '0;
      end
      if (state == GAP && last) begin
        temp1 <= shadow[0];
        temp2 <= shadow[1];
        temp3 <= shadow[2];
        temp4 <= shadow[3];
        err_mask <= pend;
      end
    end
endmodule

// File: tb/tb_temp_sensor_sequencer.sv
// tb_temp_sensor_sequencer: random sweeps checked against a per-cycle schedule model
module tb_temp_sensor_sequencer;
  localparam int W = 8;
  localparam int TO = 16;
  logic clk = 0, rst = 1, start = 0, sens_ack = 0;
  logic [W-1:0] sens_data = '0;
  logic sens_req, frame_valid, busy;
  logic [1:0] sens_sel;
  logic [W-1:0] temp1, temp2, temp3, temp4;
  logic [3:0] err_mask;
  int nvec = 0, nerr = 0;
  int lat [4];
  logic [W-1:0] dat [4];
  logic [W-1:0] pub [4];
  logic [3:0] perr = '0;
  typedef struct {bit req; bit ack; logic [1:0] sel;} ent_t;
  temp_sensor_sequencer #(.W(W), .TO_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .sens_req(sens_req), .sens_sel(sens_sel),
    .sens_ack(sens_ack), .sens_data(sens_data), .temp1(temp1), .temp2(temp2),
    .temp3(temp3), .temp4(temp4), .frame_valid(frame_valid), .err_mask(err_mask), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_idle_zero();
    chk("rst_req", sens_req, 0);
    chk("rst_sel", sens_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_temps", {temp4, temp3, temp2, temp1}, 0);
    chk("rst_err", err_mask, 0);
  endtask
  task automatic sweep(int abort_n);
    ent_t q[$];
    ent_t e;
    int len, r;
    e = '{0, 0, 2'd0};
    for (int ch = 0; ch < 4; ch++) begin
      r = (lat[ch] == 0) ? TO : lat[ch];
      for (int k = 1; k <= r; k++) q.push_back('{1, lat[ch] != 0 && k == r, 2'(ch)});
      q.push_back('{0, 0, 2'(ch)});
    end
    len = q.size();
    @(negedge clk);
    start = 1;
    sens_ack = 1'($urandom);
    sens_data = W'($urandom);
    for (int n = 1; n <= len + 2; n++) begin
      @(negedge clk);
      if (n <= len) begin
        e = q[n-1];
        chk("req", sens_req, e.req);
        if (e.req) chk("sel", sens_sel, e.sel);
        chk("fv_early", frame_valid, 0);
        chk("busy", busy, 1);
      end else if (n == len + 1) begin
        for (int i = 0; i < 4; i++) begin
          if (lat[i] != 0) pub[i] = dat[i];
          perr[i] = lat[i] == 0;
        end
        chk("fv", frame_valid, 1);
        chk("done_req", sens_req, 0);
        chk("temps", {temp4, temp3, temp2, temp1}, {pub[3], pub[2], pub[1], pub[0]});
        chk("err_mask", err_mask, perr);
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_fv", frame_valid, 0);
        chk("idle_req", sens_req, 0);
      end
      if (n == abort_n) begin
        start = 0;
        sens_ack = 0;
        #1 rst = 1;
        #1;
        for (int i = 0; i < 4; i++) pub[i] = '0;
        perr = '0;
        chk_idle_zero();
        @(negedge clk);
        rst = 0;
        chk("abort_fv", frame_valid, 0);
        return;
      end
      start = (n <= len + 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      sens_ack = (n <= len && e.req) ? e.ack : 1'($urandom);
      sens_data = (n <= len && e.req && e.ack) ? dat[e.sel] : W'($urandom);
    end
  endtask
  task automatic set_ok(logic [W-1:0] d0, logic [W-1:0] d1, logic [W-1:0] d2, logic [W-1:0] d3);
    for (int i = 0; i < 4; i++) lat[i] = 1;
    dat[0] = d0;
    dat[1] = d1;
    dat[2] = d2;
    dat[3] = d3;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) pub[i] = '0;
    #12;
    chk_idle_zero();
    @(negedge clk);
    rst = 0;
    set_ok(8'h10, 8'h20, 8'h30, 8'h40);
    sweep(0);
    set_ok(8'h11, 8'h21, 8'h7F, 8'h41);
    lat[2] = 5;
    sweep(0);
    set_ok(8'h12, 8'h22, 8'h32, 8'h42);
    sweep(0);
    set_ok(8'h13, 8'h99, 8'h33, 8'h43);
    lat[1] = 0;
    sweep(0);
    set_ok(8'h14, 8'h24, 8'h34, 8'h44);
    sweep(0);
    set_ok(8'h55, 8'h25, 8'h35, 8'h45);
    lat[0] = TO;
    sweep(0);
    set_ok(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    sweep(5);
    set_ok(8'h16, 8'h26, 8'h36, 8'h46);
    sweep(0);
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < 4; i++) begin
        lat[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TO);
        dat[i] = W'($urandom);
      end
      sweep((s % 10 == 9) ? $urandom_range(1, 6) : 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
